// File: rtl/next_pc_predictor_pkg.sv
// Shared constants and helpers for the fetch-stage next-PC predictor:
// 2-bit direction counter encodings, the sequential PC step and saturating counter math.
package next_pc_predictor_pkg;

  localparam logic [1:0] BP_CNT_SNT = 2'b00;
  localparam logic [1:0] BP_CNT_WNT = 2'b01;
  localparam logic [1:0] BP_CNT_WT  = 2'b10;
  localparam logic [1:0] BP_CNT_ST  = 2'b11;

  localparam int unsigned PC_STEP = 4;

  function automatic logic [1:0] sat_inc(input logic [1:0] cnt);
    return (cnt == BP_CNT_ST) ? BP_CNT_ST : cnt + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] cnt);
    return (cnt == BP_CNT_SNT) ? BP_CNT_SNT : cnt - 2'd1;
  endfunction

endpackage

// File: rtl/next_pc_predictor_btb_array.sv
// Direct-mapped BTB storage: valid/tag/target/counter per entry, one combinational
// lookup port and one clocked read-modify-write training port.
module btb_array
  import next_pc_predictor_pkg::*;
#(
  parameter int         XLEN      = 32,
  parameter int         ENTRIES   = 16,
  parameter logic [1:0] CNT_ALLOC = BP_CNT_WT,
  localparam int        IDX_W     = $clog2(ENTRIES),
  localparam int        TAG_W     = XLEN - IDX_W - 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [1:0]       rd_cnt,
  output logic [XLEN-1:0]  rd_tgt,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic             wr_taken,
  input  logic [XLEN-1:0]  wr_tgt
);

  logic [ENTRIES-1:0] valid_q;
  logic [1:0]         cnt_q [ENTRIES];
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [XLEN-1:0]    tgt_q [ENTRIES];
  logic               wr_hit;

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_cnt   = cnt_q[rd_idx];
  assign rd_tgt   = tgt_q[rd_idx];

  // Training decides hit/miss against the resolved PC, not the fetch PC.
  assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= BP_CNT_WNT;
    end else if (wr_en) begin
      if (wr_taken) begin
        valid_q[wr_idx] <= 1'b1;
        cnt_q[wr_idx]   <= wr_hit ? sat_inc(cnt_q[wr_idx]) : CNT_ALLOC;
      end else if (wr_hit) begin
        cnt_q[wr_idx]   <= sat_dec(cnt_q[wr_idx]);
      end
    end
  end

  // Tag and target are only meaningful once valid is set, so they carry no reset.
  always_ff @(posedge clk) begin
    if (wr_en && wr_taken) begin
      tag_q[wr_idx] <= wr_tag;
      tgt_q[wr_idx] <= wr_tgt;
    end
  end

endmodule

// File: rtl/next_pc_predictor.sv
// Fetch-stage next-PC generator: owns the fetch PC, predicts from the BTB and
// counters, trains them from execute resolution and counts redirects.
module next_pc_predictor
  import next_pc_predictor_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              BTB_ENTRIES = 16,
  parameter logic [XLEN-1:0] RESET_PC    = 32'h8000_0000,
  parameter logic [1:0]      CNT_ALLOC   = BP_CNT_WT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            ex_fix_i,
  input  logic [XLEN-1:0] ex_next_pc_i,
  input  logic            upd_valid_i,
  input  logic [XLEN-1:0] upd_pc_i,
  input  logic            upd_taken_i,
  input  logic [XLEN-1:0] upd_target_i,
  output logic [XLEN-1:0] pc_o,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pred_target_o,
  output logic [31:0]     mispred_cnt_o
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  logic [XLEN-1:0]  pc_q;
  logic [XLEN-1:0]  next_pc;
  logic [XLEN-1:0]  seq_pc;
  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  logic [1:0]       rd_cnt;
  logic [XLEN-1:0]  rd_tgt;
  logic             hit;
  logic             unused_pc_bits;

  btb_array #(
    .XLEN      (XLEN),
    .ENTRIES   (BTB_ENTRIES),
    .CNT_ALLOC (CNT_ALLOC)
  ) u_btb (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (pc_q[IDX_W+1:2]),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_cnt   (rd_cnt),
    .rd_tgt   (rd_tgt),
    .wr_en    (upd_valid_i),
    .wr_idx   (upd_pc_i[IDX_W+1:2]),
    .wr_tag   (upd_pc_i[XLEN-1:IDX_W+2]),
    .wr_taken (upd_taken_i),
    .wr_tgt   (upd_target_i)
  );

  // Low PC bits and the counter's hysteresis bit play no part in the prediction.
  assign unused_pc_bits = ^{pc_q[1:0], upd_pc_i[1:0], rd_cnt[0]};

  assign hit           = rd_valid && (rd_tag == pc_q[XLEN-1:IDX_W+2]);
  assign seq_pc        = pc_q + XLEN'(PC_STEP);
  assign pred_taken_o  = hit && rd_cnt[1];
  assign pred_target_o = pred_taken_o ? rd_tgt : seq_pc;
  assign pc_o          = pc_q;

  always_comb begin
    next_pc = pred_target_o;
    if (ex_fix_i)     next_pc = ex_next_pc_i;
    else if (stall_i) next_pc = pc_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      mispred_cnt_o <= '0;
    end else begin
      pc_q <= next_pc;
      if (ex_fix_i && (mispred_cnt_o != '1)) mispred_cnt_o <= mispred_cnt_o + 32'd1;
    end
  end

endmodule
